life_sequencer: RTL and testbench
=================================

Name: life_sequencer

Overview:
Top-level run controller for the Game of Life board datapath. It chooses the seed source (manual switches or LFSR) and warms up the LFSR before a random load. It then loads the board and steps generations, either free-running at a selectable speed or one at a time. It keeps a generation count and halts when the datapath reports an empty or static board.

Parameters:
TICK_BASE, 1250000, clock cycles between generations at speed 0; period = TICK_BASE << speed
GEN_W, 16, generation counter width
WARMUP, 8, LFSR clock-enable cycles before a random seed is loaded

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: load seed / run / re-seed
step  in  1  single-cycle pulse: advance one generation while paused
pause  in  1  single-cycle pulse: stop free-running
rand_seed  in  1  level, sampled on start: 1 selects the LFSR seed
speed  in  2  free-run rate select
step_done  in  1  datapath pulse: generation computed
board_empty  in  1  datapath flag, valid in the step_done cycle
board_static  in  1  datapath flag, valid in the step_done cycle
seed_sel  out  1  seed mux select: 0 manual, 1 LFSR
lfsr_en  out  1  LFSR clock enable
load_seed  out  1  one-cycle board load strobe
step_req  out  1  request next generation; held until step_done
running  out  1  1 while in free-run mode (RUN or a STEP from RUN)
halted  out  1  1 in HALT
gen_count  out  GEN_W  generations completed since the last load

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, gen_count 0, mode flag 0, divider cleared.
- States: IDLE, WARM, LOAD, PAUSED, RUN, STEP, HALT. Registered state; all outputs are registered or a pure decode of state.
- IDLE:
  - start with rand_seed=1 -> WARM; seed_sel latched to 1.
  - start with rand_seed=0 -> LOAD; seed_sel latched to 0.
  - step and pause are ignored.
- WARM: lfsr_en=1 for exactly WARMUP cycles, then -> LOAD. All inputs are ignored.
- LOAD: load_seed=1 for exactly one cycle; gen_count<=0 -> PAUSED. seed_sel holds its latched value through LOAD and afterwards until the next start from IDLE/HALT.
- PAUSED:
  - start -> RUN (mode=1).
  - step -> STEP (mode=0).
  - start and step together: start wins.
  - pause is ignored.
- RUN:
  - The divider counts clk cycles; at count = (TICK_BASE << speed) - 1 -> STEP, divider cleared.
  - speed is sampled every cycle, so a change takes effect on the current count.
  - pause -> PAUSED (mode=0), divider cleared.
  - pause on the terminal-count cycle: pause wins.
- STEP:
  - step_req=1 from the first STEP cycle until the step_done cycle inclusive; it drops the next cycle.
  - On step_done: gen_count+1, saturating at all-ones.
  - Then, if board_empty or board_static -> HALT; else -> RUN if mode=1, else PAUSED.
  - pause during STEP clears mode, so after step_done the block returns to PAUSED.
  - start and step are ignored in STEP.
- HALT: halted=1 and gen_count holds. start behaves as in IDLE (re-seed, rand_seed re-sampled).
- step_done outside STEP is ignored; gen_count does not change.
- running = mode flag while in RUN or STEP; 0 in all other states.
- Minimum latency from start in PAUSED to the first step_req is TICK_BASE << speed cycles.

Decomposition:
- life_pkg holds:
  - the state enum seq_state_t, 3-bit;
  - speed encodings SPD_SLOW..SPD_FAST (0..3);
  - the shared GEN_W default.
- Sub-module tick_divider (TICK_BASE, speed, enable, clear -> tick pulse). It is reusable by the display refresh logic.

Test Plan (TICK_BASE=4, WARMUP=8):
- Manual seed: start with rand_seed=0 in IDLE -> load_seed high for 1 cycle, 1 cycle after start; seed_sel=0; lfsr_en never 1; gen_count=0; state PAUSED.
- Random seed: start with rand_seed=1 -> lfsr_en high for exactly 8 consecutive cycles, then load_seed for 1 cycle with seed_sel=1.
- Free run at speed=2: start from PAUSED -> step_req asserts 16 cycles later. Respond with step_done 3 cycles later -> gen_count=1, next step_req asserts 16 cycles later; repeat to gen_count=5.
- Single step and pause:
  - step in PAUSED -> step_req; step_done -> gen_count+1, back to PAUSED, running=0.
  - pause during STEP in RUN -> PAUSED after step_done.
- Halt: step_done with board_static=1 -> halted=1, gen_count holds. A later start with rand_seed=0 -> load_seed pulse, gen_count=0.
- Reset mid-STEP: drive reset=0 while step_req=1 -> immediately all outputs 0 and state IDLE. A stray step_done after release leaves gen_count=0.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life run controller and its helpers.
package life_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARM   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_RUN    = 3'd4,
    ST_STEP   = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  localparam logic [1:0] SPD_SLOW  = 2'd0;
  localparam logic [1:0] SPD_MID   = 2'd1;
  localparam logic [1:0] SPD_QUICK = 2'd2;
  localparam logic [1:0] SPD_FAST  = 2'd3;

  localparam int GEN_W_DEFAULT = 16;

endpackage

// File: rtl/tick_divider.sv
// Programmable tick generator: one-cycle tick every (TICK_BASE << speed) enabled cycles.
module tick_divider #(
  parameter int TICK_BASE = 1250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       enable,
  input  logic       clear,
  output logic       tick
);

  // Headroom for the largest shift (<< 3) even when TICK_BASE is a power of two.
  localparam int CNT_W = $clog2(TICK_BASE) + 4;
  localparam logic [CNT_W-1:0] BASE = CNT_W'(TICK_BASE);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] period_m1;

  assign period_m1 = (BASE << speed) - CNT_W'(1);

  // ">=" so that lowering speed past the current count still fires promptly.
  assign tick = enable && (count_reg >= period_m1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear || !enable || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Run controller for the Life board: seed selection, LFSR warm-up, load,
// free-run / single-step generation sequencing, generation count and halt.
module life_sequencer
  import life_pkg::*;
#(
  parameter int TICK_BASE = 1250000,
  parameter int GEN_W     = GEN_W_DEFAULT,
  parameter int WARMUP    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             pause,
  input  logic             rand_seed,
  input  logic [1:0]       speed,
  input  logic             step_done,
  input  logic             board_empty,
  input  logic             board_static,
  output logic             seed_sel,
  output logic             lfsr_en,
  output logic             load_seed,
  output logic             step_req,
  output logic             running,
  output logic             halted,
  output logic [GEN_W-1:0] gen_count
);

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);

  seq_state_t        state_reg;
  logic              mode_reg;
  logic              seed_sel_reg;
  logic [WARM_W-1:0] warm_cnt_reg;
  logic [GEN_W-1:0]  gen_count_reg;
  logic              run_en;
  logic              tick;

  assign run_en = (state_reg == ST_RUN);

  tick_divider #(
    .TICK_BASE(TICK_BASE)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .speed (speed),
    .enable(run_en),
    .clear (pause),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      mode_reg      <= 1'b0;
      seed_sel_reg  <= 1'b0;
      warm_cnt_reg  <= '0;
      gen_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            seed_sel_reg <= rand_seed;
            warm_cnt_reg <= '0;
            state_reg    <= rand_seed ? ST_WARM : ST_LOAD;
          end
        end
        ST_WARM: begin
          if (warm_cnt_reg == WARM_LAST) begin
            warm_cnt_reg <= '0;
            state_reg    <= ST_LOAD;
          end else begin
            warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
          end
        end
        ST_LOAD: begin
          gen_count_reg <= '0;
          mode_reg      <= 1'b0;
          state_reg     <= ST_PAUSED;
        end
        ST_PAUSED: begin
          if (start) begin
            mode_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end else if (step) begin
            mode_reg  <= 1'b0;
            state_reg <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (pause) begin
            mode_reg  <= 1'b0;
            state_reg <= ST_PAUSED;
          end else if (tick) begin
            state_reg <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (pause) begin
            mode_reg <= 1'b0;
          end
          if (step_done) begin
            if (gen_count_reg != '1) begin
              gen_count_reg <= gen_count_reg + GEN_W'(1);
            end
            // A pause landing with step_done still drops back to PAUSED.
            if (board_empty || board_static) begin
              state_reg <= ST_HALT;
            end else if (mode_reg && !pause) begin
              state_reg <= ST_RUN;
            end else begin
              state_reg <= ST_PAUSED;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign seed_sel  = seed_sel_reg;
  assign gen_count = gen_count_reg;
  assign lfsr_en   = (state_reg == ST_WARM);
  assign load_seed = (state_reg == ST_LOAD);
  assign step_req  = (state_reg == ST_STEP);
  assign halted    = (state_reg == ST_HALT);
  assign running   = mode_reg && ((state_reg == ST_RUN) || (state_reg == ST_STEP));

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a per-cycle reference model check.
module tb_life_sequencer;

  localparam int TB_TICK  = 4;
  localparam int TB_WARM  = 8;
  localparam int TB_GEN_W = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, step = 1'b0, pause = 1'b0, rand_seed = 1'b0;
  logic       step_done = 1'b0, board_empty = 1'b0, board_static = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       seed_sel, lfsr_en, load_seed, step_req, running, halted;
  logic [TB_GEN_W-1:0] gen_count;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: activity flags and countdowns rather than a state code.
  bit m_await_start, m_halt, m_load, m_paused, m_wait, m_step, m_free, m_sel;
  int m_warm_left, m_elapsed, m_gen;

  life_sequencer #(
    .TICK_BASE(TB_TICK),
    .GEN_W    (TB_GEN_W),
    .WARMUP   (TB_WARM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .step        (step),
    .pause       (pause),
    .rand_seed   (rand_seed),
    .speed       (speed),
    .step_done   (step_done),
    .board_empty (board_empty),
    .board_static(board_static),
    .seed_sel    (seed_sel),
    .lfsr_en     (lfsr_en),
    .load_seed   (load_seed),
    .step_req    (step_req),
    .running     (running),
    .halted      (halted),
    .gen_count   (gen_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    m_await_start = 1'b1; m_halt = 1'b0; m_load = 1'b0; m_paused = 1'b0;
    m_wait = 1'b0; m_step = 1'b0; m_free = 1'b0; m_sel = 1'b0;
    m_warm_left = 0; m_elapsed = 0; m_gen = 0;
  endtask

  task automatic m_advance();
    int period;
    period = TB_TICK << speed;
    if (m_warm_left > 0) begin
      m_warm_left--;
      if (m_warm_left == 0) m_load = 1'b1;
    end else if (m_load) begin
      m_load = 1'b0; m_gen = 0; m_paused = 1'b1; m_free = 1'b0;
    end else if (m_await_start || m_halt) begin
      if (start) begin
        m_await_start = 1'b0; m_halt = 1'b0; m_sel = rand_seed;
        if (rand_seed) m_warm_left = TB_WARM;
        else m_load = 1'b1;
      end
    end else if (m_paused) begin
      if (start) begin
        m_paused = 1'b0; m_wait = 1'b1; m_free = 1'b1; m_elapsed = 0;
      end else if (step) begin
        m_paused = 1'b0; m_step = 1'b1; m_free = 1'b0;
      end
    end else if (m_wait) begin
      if (pause) begin
        m_wait = 1'b0; m_paused = 1'b1; m_free = 1'b0;
      end else if (m_elapsed + 1 >= period) begin
        m_wait = 1'b0; m_step = 1'b1;
      end else begin
        m_elapsed++;
      end
    end else if (m_step) begin
      if (pause) m_free = 1'b0;
      if (step_done) begin
        m_step = 1'b0;
        if (m_gen < (1 << TB_GEN_W) - 1) m_gen++;
        if (board_empty || board_static) m_halt = 1'b1;
        else if (m_free) begin m_wait = 1'b1; m_elapsed = 0; end
        else m_paused = 1'b1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_advance();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_lfsr_en",   lfsr_en,   int'(m_warm_left > 0));
        check("cyc_load_seed", load_seed, m_load);
        check("cyc_seed_sel",  seed_sel,  m_sel);
        check("cyc_step_req",  step_req,  m_step);
        check("cyc_running",   running,   int'(m_free && (m_wait || m_step)));
        check("cyc_halted",    halted,    m_halt);
        check("cyc_gen_count", gen_count, m_gen);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic rs);
    @(negedge clk); start = 1'b1; rand_seed = rs;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  task automatic pulse_pause();
    @(negedge clk); pause = 1'b1;
    @(negedge clk); pause = 1'b0;
  endtask

  // Counts negedges until step_req is seen; an expired budget is a failure.
  task automatic wait_req(output int cycles);
    cycles = 0;
    while (!step_req && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (!step_req) check("step_req_timeout", step_req, 1);
  endtask

  task automatic respond(input int delay, input logic empty, input logic stat);
    repeat (delay) @(negedge clk);
    step_done = 1'b1; board_empty = empty; board_static = stat;
    @(negedge clk);
    step_done = 1'b0; board_empty = 1'b0; board_static = 1'b0;
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clk);
    check("rst_step_req", step_req, 0);
    check("rst_gen", gen_count, 0);
    check("rst_seed_sel", seed_sel, 0);
    reset = 1'b1;
    chk_en = 1'b1;

    // Manual seed from IDLE; step/pause ignored there
    pulse_step();
    pulse_pause();
    pulse_start(1'b0);
    check("man_load_seed", load_seed, 1);
    check("man_seed_sel", seed_sel, 0);
    @(negedge clk);
    check("man_load_drop", load_seed, 0);
    check("man_gen", gen_count, 0);
    $display("manual seed loaded, gen=%0d", gen_count);

    // Free run at speed 2: 16-cycle period, step_done 3 cycles after request
    speed = 2'd2;
    pulse_start(1'b0);
    for (int g = 1; g <= 5; g++) begin
      wait_req(c);
      check("run_latency", c, 16);
      respond(3, 1'b0, 1'b0);
      check("run_gen", gen_count, g);
      $display("free-run generation %0d, latency %0d", gen_count, c);
    end

    // Pause during a free-run STEP returns to PAUSED after step_done
    wait_req(c);
    check("run_latency6", c, 16);
    pulse_pause();
    respond(1, 1'b0, 1'b0);
    check("pause_in_step_running", running, 0);
    check("pause_in_step_gen", gen_count, 6);
    repeat (40) @(negedge clk);
    check("paused_no_req", step_req, 0);
    $display("pause during step, gen=%0d", gen_count);

    // Single step from PAUSED
    pulse_step();
    check("single_step_req", step_req, 1);
    check("single_step_running", running, 0);
    respond(1, 1'b0, 1'b0);
    check("single_step_gen", gen_count, 7);
    check("single_step_req_drop", step_req, 0);
    $display("single step, gen=%0d", gen_count);

    // start+step together: start wins; speed lowered mid-count
    speed = 2'd3;
    @(negedge clk); start = 1'b1; step = 1'b1;
    @(negedge clk); start = 1'b0; step = 1'b0;
    check("start_wins_running", running, 1);
    check("start_wins_no_req", step_req, 0);
    repeat (5) @(negedge clk);
    speed = 2'd0;
    wait_req(c);
    check("speed_change_latency", c, 1);
    respond(1, 1'b0, 1'b0);
    check("speed_change_gen", gen_count, 8);
    $display("speed change, gen=%0d", gen_count);

    // Pause mid-count in RUN
    repeat (2) @(negedge clk);
    pulse_pause();
    check("run_pause_running", running, 0);
    repeat (12) @(negedge clk);
    check("run_pause_no_req", step_req, 0);
    $display("paused from run, gen=%0d", gen_count);

    // Halt on static board; stray step_done in HALT ignored
    pulse_step();
    respond(2, 1'b0, 1'b1);
    check("halt_static", halted, 1);
    check("halt_gen", gen_count, 9);
    respond(1, 1'b0, 1'b0);
    check("halt_stray_gen", gen_count, 9);
    $display("halted on static board, gen=%0d", gen_count);

    // Re-seed from HALT, then halt on empty board
    pulse_start(1'b0);
    check("reseed_load", load_seed, 1);
    check("reseed_halt_drop", halted, 0);
    @(negedge clk);
    check("reseed_gen", gen_count, 0);
    pulse_step();
    respond(0, 1'b1, 1'b0);
    check("halt_empty", halted, 1);
    check("halt_empty_gen", gen_count, 1);
    $display("halted on empty board, gen=%0d", gen_count);

    // Random seed from HALT: eight LFSR cycles then a load with seed_sel=1
    pulse_start(1'b1);
    c = 0;
    while (lfsr_en && c < 50) begin
      c++;
      @(negedge clk);
    end
    check("rand_warm_cycles", c, TB_WARM);
    check("rand_load", load_seed, 1);
    check("rand_seed_sel", seed_sel, 1);
    $display("random seed loaded after %0d warm-up cycles", c);

    // Asynchronous reset mid-STEP
    @(negedge clk);
    pulse_step();
    check("pre_reset_req", step_req, 1);
    #2 reset = 1'b0;
    #1;
    check("areset_step_req", step_req, 0);
    check("areset_seed_sel", seed_sel, 0);
    check("areset_lfsr_en", lfsr_en, 0);
    check("areset_load_seed", load_seed, 0);
    check("areset_running", running, 0);
    check("areset_halted", halted, 0);
    check("areset_gen", gen_count, 0);
    @(negedge clk);
    reset = 1'b1;
    respond(1, 1'b0, 1'b0);
    check("stray_done_gen", gen_count, 0);
    check("stray_done_req", step_req, 0);
    $display("reset mid-step, gen=%0d", gen_count);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
